// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: memory-wait FSM encoding and default access timeout.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } mem_state_e;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/mem_wait_fsm.sv
// RUN/MEM_WAIT tracker for the MEM-stage access; aborts the access with a one-cycle error
// pulse once it has waited TIMEOUT cycles.
module mem_wait_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic mem_wait_o,
  output logic mem_err_o
);

  localparam int unsigned WcntW = $clog2(TIMEOUT + 1);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(TIMEOUT - 1);

  mem_state_e state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d = StMemWait;
          wcnt_d  = '0;
        end
      end
      StMemWait: begin
        wcnt_d = wcnt_q + 1'b1;
        if (mem_ready_i) begin
          state_d = StRun;
        end else if (wcnt_q == WcntLast) begin
          state_d   = StRun;
          mem_err_o = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    // A reset abandons the access silently.
    if (rst_i) begin
      mem_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mem_wait_o = (state_q == StMemWait);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush and data-hazard bubble insertion,
// prioritised in that order, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             forward_en_i,
  input  logic [3:0]       src1_i,
  input  logic [3:0]       src2_i,
  input  logic             two_src_i,
  input  logic [3:0]       exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [3:0]       mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             freeze_pc_o,
  output logic             freeze_if_o,
  output logic             freeze_all_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic mem_wait;
  logic mem_frz;
  logic exe_hz1, exe_hz2, mem_hz1, mem_hz2;
  logic hz;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  mem_wait_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_wait_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mem_req_i  (mem_req_i),
    .mem_ready_i(mem_ready_i),
    .mem_wait_o (mem_wait),
    .mem_err_o  (mem_err_o)
  );

  assign exe_hz1 = exe_wb_en_i && (src1_i == exe_dest_i);
  assign exe_hz2 = two_src_i && exe_wb_en_i && (src2_i == exe_dest_i);
  assign mem_hz1 = mem_wb_en_i && (src1_i == mem_dest_i);
  assign mem_hz2 = two_src_i && mem_wb_en_i && (src2_i == mem_dest_i);

  // With forwarding only a load in EXE cannot be bypassed.
  assign hz = forward_en_i ? (exe_mem_r_en_i && (exe_hz1 || exe_hz2))
                           : (exe_hz1 || exe_hz2 || mem_hz1 || mem_hz2);

  assign mem_frz = mem_wait || (mem_req_i && !mem_ready_i);

  always_comb begin
    freeze_all_o = 1'b0;
    freeze_pc_o  = 1'b0;
    flush_if_o   = 1'b0;
    flush_id_o   = 1'b0;
    if (!rst_i) begin
      if (mem_frz) begin
        freeze_all_o = 1'b1;
        freeze_pc_o  = 1'b1;
      end else if (branch_taken_i) begin
        flush_if_o = 1'b1;
        flush_id_o = 1'b1;
      end else if (hz) begin
        freeze_pc_o = 1'b1;
        flush_id_o  = 1'b1;
      end
    end
  end

  assign freeze_if_o = freeze_pc_o;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze_pc_o && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_if_o && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
- REQ-001: Parameter TIMEOUT, default 255: maximum number of MEM_WAIT cycles before the controller aborts the access.
- REQ-002: Parameter CNT_W, default 16: width of each performance counter.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: forward_en  input  1  1 = forwarding unit active; 0 = no forwarding.
- REQ-006: src1, src2  input  4 each  ID-stage source register numbers.
- REQ-007: two_src  input  1  src2 is read by the ID-stage instruction.
- REQ-008: exe_dest, exe_wb_en, exe_mem_r_en  input  4/1/1  destination and controls of the instruction in EXE.
- REQ-009: mem_dest, mem_wb_en  input  4/1  destination and write-back enable of the instruction in MEM.
- REQ-010: branch_taken  input  1  the EXE-stage branch resolves taken.
- REQ-011: mem_req, mem_ready  input  1 each  MEM-stage access request, and external memory completion.
- REQ-012: freeze_pc, freeze_if  output  1 each  hold the PC register and the IF/ID register.
- REQ-013: freeze_all  output  1  hold the ID/EX, EXE/MEM and MEM/WB registers.
- REQ-014: flush_if, flush_id  output  1 each  clear the IF/ID register and the ID/EX register.
- REQ-015: mem_err  output  1  one-cycle pulse on an access timeout.
- REQ-016: stall_cnt, flush_cnt  output  CNT_W each  saturating performance counters.

Function
- REQ-017: The FSM SHALL have two states, RUN and MEM_WAIT, and a wait counter wcnt of ceil(log2(TIMEOUT+1)) bits.
- REQ-018: In RUN, mem_req=1 with mem_ready=0 SHALL move the FSM to MEM_WAIT on the next edge and clear wcnt.
- REQ-019: In MEM_WAIT, wcnt SHALL increment each cycle.
- REQ-020: In MEM_WAIT, mem_ready=1 SHALL return the FSM to RUN.
- REQ-021: In MEM_WAIT, wcnt==TIMEOUT-1 with mem_ready=0 SHALL return the FSM to RUN and pulse mem_err for exactly that cycle.
- REQ-022: freeze_all, freeze_pc and freeze_if SHALL equal (state==MEM_WAIT) or (state==RUN and mem_req and !mem_ready), combinationally in the same cycle.
- REQ-023: Hazard term hz = (exe_wb_en and src1==exe_dest) or (two_src and exe_wb_en and src2==exe_dest) or (mem_wb_en and src1==mem_dest) or (two_src and mem_wb_en and src2==mem_dest).
- REQ-024: When forward_en=1, the hazard term SHALL be restricted to the EXE-stage terms, each gated by exe_mem_r_en (load-use only).
- REQ-025: When there is no memory freeze, branch_taken SHALL assert flush_if and flush_id combinationally and SHALL override the hazard term.
- REQ-026: When there is no memory freeze and no branch, the hazard term SHALL assert freeze_pc, freeze_if and flush_id (bubble insertion), for a latency of 0 cycles.
- REQ-027: Priority SHALL be memory freeze > branch > data hazard; flush_* SHALL never be 1 in a cycle where freeze_all=1.
- REQ-028: stall_cnt SHALL increment once per cycle in which freeze_pc=1.
- REQ-029: flush_cnt SHALL increment once per cycle in which flush_if=1.
- REQ-030: Both counters SHALL saturate at all-ones and SHALL not wrap.
- REQ-031: Outputs SHALL depend only on the current inputs and the registered state; there SHALL be no combinational path from any output back to an input.

Reset
- REQ-032: rst=1 at a clock edge SHALL force state=RUN, wcnt=0, mem_err=0, stall_cnt=0 and flush_cnt=0, overriding all other events on that edge.
- REQ-033: While rst=1, every freeze and flush output SHALL be 0.
- REQ-034: A reset asserted during MEM_WAIT SHALL abandon the access without pulsing mem_err.

Structure
- REQ-035: State encoding (RUN=0, MEM_WAIT=1) and the default TIMEOUT SHALL live in the shared pipeline package.
- REQ-036: The RUN/MEM_WAIT FSM with wcnt SHALL be one sub-module, mem_wait_fsm.
- REQ-037: The hazard comparison and priority logic SHALL stay in the top module.

Verification
- REQ-038: forward_en=0, src1=3, exe_dest=3, exe_wb_en=1 -> freeze_pc=1, freeze_if=1, flush_id=1, flush_if=0; stall_cnt advances by 1.
- REQ-039: forward_en=1, same stimulus with exe_mem_r_en=0 -> no stall; with exe_mem_r_en=1 -> one-cycle bubble.
- REQ-040: branch_taken=1 together with a hazard -> flush_if=1, flush_id=1, freeze_pc=0; flush_cnt advances by 1.
- REQ-041: mem_req=1, mem_ready low for 4 cycles then high -> freeze_all=1 for 5 cycles, then 0; state back to RUN; no flush during the freeze.
- REQ-042: TIMEOUT=8, mem_ready held at 0 -> mem_err pulses once in the 8th MEM_WAIT cycle, then the FSM is in RUN.
- REQ-043: rst asserted in the 2nd MEM_WAIT cycle -> next cycle state=RUN, counters=0, mem_err never asserted; separately, force stall_cnt to all-ones then stall -> stall_cnt stays at all-ones.
